// File: rtl/neuron_engine_pkg.sv
// Shared constants and FSM encoding for the neuron engine and its controller.
package neuron_engine_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  localparam int SHIFT_DEF  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/neuron_engine_mac_datapath.sv
// Signed multiply-accumulate: clr zeroes the sum, en adds the full-width product.
module mac_datapath #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_d, acc_q;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/neuron_engine.sv
// Dot-product neuron: streams N activation/weight pairs from memory, accumulates,
// then applies ReLU and saturating fixed-point rescale to produce one result.
module neuron_engine
  import neuron_engine_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         vec_len,
  input  logic [ADDR_W-1:0]        base_in,
  input  logic [ADDR_W-1:0]        base_w,
  output logic                     busy,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        in_addr,
  output logic [ADDR_W-1:0]        w_addr,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0]        result,
  output logic                     done
);

  localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        k_q, k_d;
  logic [ADDR_W-1:0]       in_addr_q, in_addr_d;
  logic [ADDR_W-1:0]       w_addr_q, w_addr_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]       result_q, result_d;
  logic                    start_ok;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic [DATA_W-1:0]       relu_sat;

  assign start_ok = start && (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (vec_len == '0) ? OUT : FETCH;
      FETCH:   if (k_q == len_q - LEN_W'(1)) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mem_rd_en = (state_q == FETCH);
    done      = (state_q == OUT);
  end

  // Read data arrives one cycle after the strobe, so accumulation lags by one.
  always_comb begin
    len_d     = len_q;
    k_d       = k_q;
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    result_d  = result_q;
    rd_vld_d  = (state_q == FETCH);
    if (start_ok) begin
      len_d     = vec_len;
      k_d       = '0;
      in_addr_d = base_in;
      w_addr_d  = base_w;
    end else if (state_q == FETCH) begin
      k_d       = k_q + LEN_W'(1);
      in_addr_d = in_addr_q + ADDR_W'(1);
      w_addr_d  = w_addr_q + ADDR_W'(1);
    end else if (state_q == OUT) begin
      result_d  = relu_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      k_q       <= '0;
      in_addr_q <= '0;
      w_addr_q  <= '0;
      rd_vld_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      len_q     <= len_d;
      k_q       <= k_d;
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
      rd_vld_q  <= rd_vld_d;
      result_q  <= result_d;
    end
  end

  mac_datapath #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (rd_vld_q),
    .a   (in_data),
    .b   (w_data),
    .acc (acc)
  );

  // Sign bit test avoids an unsigned compare against a fill literal.
  always_comb begin
    shifted = acc >>> SHIFT;
    if (acc[ACC_W-1] || (acc == '0)) begin
      relu_sat = '0;
    end else if (shifted > RES_MAX) begin
      relu_sat = RES_MAX[DATA_W-1:0];
    end else begin
      relu_sat = shifted[DATA_W-1:0];
    end
  end

  assign in_addr = in_addr_q;
  assign w_addr  = w_addr_q;
  assign result  = (state_q == OUT) ? relu_sat : result_q;

endmodule

// File: tb/tb_neuron_engine.sv
// Directed bench for neuron_engine: vector table plus corner-case sequences.
module tb_neuron_engine;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        vec_len;
  logic [7:0]        base_in;
  logic [7:0]        base_w;
  logic              busy;
  logic              mem_rd_en;
  logic [7:0]        in_addr;
  logic [7:0]        w_addr;
  logic signed [7:0] in_data;
  logic signed [7:0] w_data;
  logic [7:0]        result;
  logic              done;

  logic signed [7:0] act_mem [256];
  logic signed [7:0] w_mem   [256];

  int checks   = 0;
  int failures = 0;
  int rd_cnt   = 0;
  logic [7:0] addr_q [$];

  typedef struct {
    int             len;
    int             bi;
    int             bw;
    logic [3:0][7:0] a;
    logic [3:0][7:0] w;
    int             exp;
  } vec_t;

  vec_t vt [8];

  always #5 clk = ~clk;

  neuron_engine #(
    .DATA_W (8),
    .LEN_W  (8),
    .ADDR_W (8),
    .ACC_W  (24),
    .SHIFT  (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_len   (vec_len),
    .base_in   (base_in),
    .base_w    (base_w),
    .busy      (busy),
    .mem_rd_en (mem_rd_en),
    .in_addr   (in_addr),
    .w_addr    (w_addr),
    .in_data   (in_data),
    .w_data    (w_data),
    .result    (result),
    .done      (done)
  );

  // Synchronous-read memory model: data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      in_data <= act_mem[in_addr];
      w_data  <= w_mem[w_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_cnt = rd_cnt + 1;
      addr_q.push_back(in_addr);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input int bi, input int bw,
                              input int a0, input int a1, input int a2, input int a3,
                              input int w0, input int w1, input int w2, input int w3,
                              input int exp);
    vec_t v;
    v.len = len; v.bi = bi; v.bw = bw; v.exp = exp;
    v.a[0] = a0[7:0]; v.a[1] = a1[7:0]; v.a[2] = a2[7:0]; v.a[3] = a3[7:0];
    v.w[0] = w0[7:0]; v.w[1] = w1[7:0]; v.w[2] = w2[7:0]; v.w[3] = w3[7:0];
    return v;
  endfunction

  task automatic load(input vec_t v);
    logic [7:0] ia, iw;
    for (int i = 0; i < 4; i++) begin
      ia = 8'(v.bi + i);
      iw = 8'(v.bw + i);
      act_mem[ia] = v.a[i];
      w_mem[iw]   = v.w[i];
    end
  endtask

  task automatic run_op(input int len, input int bi, input int bw, output int lat);
    rd_cnt = 0;
    addr_q.delete();
    @(negedge clk);
    start = 1'b1; vec_len = len[7:0]; base_in = bi[7:0]; base_w = bw[7:0];
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat = lat + 1;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    int lat;
    int cyc;
    int done_seen;

    for (int i = 0; i < 256; i++) begin
      act_mem[i] = '0;
      w_mem[i]   = '0;
    end
    in_data = '0; w_data = '0;
    rst = 1'b1; start = 1'b0; vec_len = '0; base_in = '0; base_w = '0;

    // len, base_in, base_w, a[0..3], w[0..3], expected result
    vt[0] = mk(4,   0,   0,    2,    4,    6,   8,   64,   64,   64,  64,  10);
    vt[1] = mk(4,  16,  32,    1,    2,    3,   4, -128, -128, -128, -128,  0);
    vt[2] = mk(2,  40,  50,   -5,    3,    0,   0,  100,  100,    0,   0,   0);
    vt[3] = mk(1,  60,  70,  127,    0,    0,   0,  127,    0,    0,   0, 126);
    vt[4] = mk(3,  80,  90,    1,    1,    1,   0,    1,    1,    1,   0,   0);
    vt[5] = mk(3, 100, 110, -128, -128, -128,   0, -128, -128, -128,   0, 127);
    vt[6] = mk(4, 120, 130,   10,   -3,    7,   2,   20,    5,   -6,  64,   2);
    vt[7] = mk(2, 140, 150,   64,    2,    0,   0,    2,    0,    0,   0,   1);

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_in_addr", int'(in_addr), 0);
    rst = 1'b0;

    for (int t = 0; t < 8; t++) begin
      load(vt[t]);
      run_op(vt[t].len, vt[t].bi, vt[t].bw, lat);
      chk($sformatf("v%0d_latency", t), lat, vt[t].len + 2);
      chk($sformatf("v%0d_result", t), int'(result), vt[t].exp);
      chk($sformatf("v%0d_reads", t), rd_cnt, vt[t].len);
      @(negedge clk);
      chk($sformatf("v%0d_hold", t), int'(result), vt[t].exp);
      chk($sformatf("v%0d_done_pulse", t), int'(done), 0);
      chk($sformatf("v%0d_idle", t), int'(busy), 0);
    end

    // Long vector: 255 * 127 * 127 stays in range, result saturates.
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = 8'sd127;
      w_mem[i]   = 8'sd127;
    end
    run_op(255, 0, 0, lat);
    chk("long_latency", lat, 257);
    chk("long_result", int'(result), 127);
    chk("long_reads", rd_cnt, 255);

    // Zero-length command after a nonzero result.
    vt[0].bi = 0; vt[0].bw = 0;
    load(vt[0]);
    run_op(4, 0, 0, lat);
    chk("pre_zero_result", int'(result), 10);
    run_op(0, 0, 0, lat);
    chk("zero_latency", lat, 1);
    chk("zero_result", int'(result), 0);
    chk("zero_reads", rd_cnt, 0);

    // Address wrap, start during FETCH, start in the done cycle.
    act_mem[254] = 8'sd1; act_mem[255] = 8'sd2; act_mem[0] = 8'sd3;
    w_mem[10] = 8'sd64; w_mem[11] = 8'sd64; w_mem[12] = 8'sd64;
    rd_cnt = 0;
    addr_q.delete();
    @(negedge clk);
    start = 1'b1; vec_len = 8'd3; base_in = 8'd254; base_w = 8'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; vec_len = 8'd8; base_in = 8'd0; base_w = 8'd0;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc = cyc + 1;
    end
    chk("wrap_latency", done ? cyc : -1, 5);
    chk("wrap_result", int'(result), 3);
    chk("wrap_reads", rd_cnt, 3);
    chk("wrap_addr0", (addr_q.size() > 0) ? int'(addr_q[0]) : -1, 254);
    chk("wrap_addr1", (addr_q.size() > 1) ? int'(addr_q[1]) : -1, 255);
    chk("wrap_addr2", (addr_q.size() > 2) ? int'(addr_q[2]) : -1, 0);
    start = 1'b1; vec_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_busy_c6", int'(busy), 0);
    @(negedge clk);
    chk("done_start_busy_c7", int'(busy), 0);
    chk("done_start_rd_en", int'(mem_rd_en), 0);
    chk("done_start_result", int'(result), 3);

    // Reset mid-operation.
    @(negedge clk);
    start = 1'b1; vec_len = 8'd8; base_in = 8'd0; base_w = 8'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_rd_en", int'(mem_rd_en), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_in_addr", int'(in_addr), 0);
    chk("abort_w_addr", int'(w_addr), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) done_seen = done_seen + 1;
    end
    chk("abort_no_done", done_seen, 0);
    load(vt[6]);
    run_op(vt[6].len, vt[6].bi, vt[6].bw, lat);
    chk("post_abort_latency", lat, 6);
    chk("post_abort_result", int'(result), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
